// File: rtl/btn_cond_pkg.sv
// Shared definitions for the push-button conditioner: per-channel FSM encoding
// and a constant-function width helper for the debounce and repeat counters.
package btn_cond_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } btn_state_e;

    // Bits needed to hold every value 0..max_val (at least 1).
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((longint'(1) << w) <= longint'(max_val)) w++;
        return w;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, optional inversion, debounce FSM with a
// saturating stability counter, registered level/press/release outputs.
// Auto-repeat of press pulses while held is built only when AUTOREPEAT_EN is defined.
module btn_debounce_ch
    import btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int ACTIVE_LOW      = 0,
    parameter int REPEAT_DELAY    = 6000000,
    parameter int REPEAT_PERIOD   = 1200000
) (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic press,
    output logic release_pulse
);

    localparam int             CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end

    logic [1:0]  sync;
    logic        s;
    btn_state_e  state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic        press_nxt, release_nxt, level_nxt;
    logic        rep_fire;

    always_ff @(posedge clock) begin
        if (reset) sync <= '0;
        else       sync <= {sync[0], pin};
    end

    assign s = (ACTIVE_LOW != 0) ? ~sync[1] : sync[1];

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            level         <= level_nxt;
            press         <= press_nxt;
            release_pulse <= release_nxt;
        end
    end

    // The counter only advances while below CNT_MAX, so it saturates instead of wrapping.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (s) begin
                    state_nxt = PRESS_CHK;
                    cnt_nxt   = CNT_ONE;
                end
            end
            PRESS_CHK: begin
                if (!s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt >= CNT_MAX) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            HELD: begin
                if (!s) begin
                    state_nxt = RELEASE_CHK;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    press_nxt = rep_fire;
                end
            end
            RELEASE_CHK: begin
                if (s) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt >= CNT_MAX) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt     = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        level_nxt = (state_nxt == HELD) || (state_nxt == RELEASE_CHK);
    end

`ifdef AUTOREPEAT_EN
    localparam int            RW      = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [RW-1:0] RPT_DLY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RPT_PER = RW'(REPEAT_PERIOD);

    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_target;
    logic          rep_armed;

    // First repeat after REPEAT_DELAY held cycles, then every REPEAT_PERIOD.
    assign rep_target = rep_armed ? RPT_PER : RPT_DLY;
    assign rep_fire   = (state == HELD) && s && ((rep_cnt + RW'(1)) == rep_target);

    // Holds through RELEASE_CHK so a glitch does not restart the repeat timing.
    always_ff @(posedge clock) begin
        if (reset || state == IDLE || state == PRESS_CHK) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else if (state == HELD && s) begin
            if (rep_fire) begin
                rep_cnt   <= '0;
                rep_armed <= 1'b1;
            end else begin
                rep_cnt   <= rep_cnt + RW'(1);
            end
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: N_BTN independent synchronise/debounce channels producing
// clean level, press and release pulses. Define AUTOREPEAT_EN for held-key repeats.
module button_conditioner
    import btn_cond_pkg::*;
#(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int ACTIVE_LOW      = 0,
    parameter int REPEAT_DELAY    = 6000000,
    parameter int REPEAT_PERIOD   = 1200000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] release_pulse
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clock         (clock),
            .reset         (reset),
            .pin           (btn_raw[i]),
            .level         (level[i]),
            .press         (press[i]),
            .release_pulse (release_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a 4-cycle debounce: cycle-by-cycle
// vector table plus hand sequences for reset mid-debounce and auto-repeat.
module tb_button_conditioner;

    localparam int N  = 3;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;
`ifdef AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic [N-1:0] btn_raw;
    logic [N-1:0] level, press, release_pulse;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [N-1:0] raw;
        logic [N-1:0] lvl;
        logic [N-1:0] prs;
        logic [N-1:0] rel;
    } vec_t;
    vec_t vecs[$];

    button_conditioner #(
        .N_BTN(N), .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW(0),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clock(clock), .reset(reset), .btn_raw(btn_raw),
        .level(level), .press(press), .release_pulse(release_pulse)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic [N-1:0] raw, input int n,
                       input logic [N-1:0] lvl, input logic [N-1:0] prs, input logic [N-1:0] rel);
        vec_t v;
        v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    initial begin
        reset   = 1'b1;
        btn_raw = '0;
        repeat (3) tick();
        chk("reset_level", level, 3'b000);
        chk("reset_press", press, 3'b000);
        chk("reset_release", release_pulse, 3'b000);
        reset = 1'b0;

        // idle
        add(3'b000, 10, 3'b000, 3'b000, 3'b000);
        // btn1 bounce: high for 3 edges
        add(3'b010, 3, 3'b000, 3'b000, 3'b000);
        add(3'b000, 6, 3'b000, 3'b000, 3'b000);
        // btn0 press: pulse on the 7th edge of the held pin
        add(3'b001, 6, 3'b000, 3'b000, 3'b000);
        add(3'b001, 1, 3'b001, 3'b001, 3'b000);
        add(3'b001, 1, 3'b001, 3'b000, 3'b000);
        // 2-cycle low glitch while held: no release
        add(3'b000, 2, 3'b001, 3'b000, 3'b000);
        add(3'b001, 2, 3'b001, 3'b000, 3'b000);
        // real release of btn0
        add(3'b000, 6, 3'b001, 3'b000, 3'b000);
        add(3'b000, 1, 3'b000, 3'b000, 3'b001);
        add(3'b000, 3, 3'b000, 3'b000, 3'b000);
        // btn0 and btn2 together, then released together
        add(3'b101, 6, 3'b000, 3'b000, 3'b000);
        add(3'b101, 1, 3'b101, 3'b101, 3'b000);
        add(3'b000, 6, 3'b101, 3'b000, 3'b000);
        add(3'b000, 1, 3'b000, 3'b000, 3'b101);
        add(3'b000, 2, 3'b000, 3'b000, 3'b000);

        foreach (vecs[i]) begin
            btn_raw = vecs[i].raw;
            tick();
            chk($sformatf("vec%0d_level", i), level, vecs[i].lvl);
            chk($sformatf("vec%0d_press", i), press, vecs[i].prs);
            chk($sformatf("vec%0d_release", i), release_pulse, vecs[i].rel);
        end

        // reset while btn0 is mid-debounce, button held through reset
        btn_raw = 3'b001;
        repeat (3) tick();
        chk("pre_rst_press", press, 3'b000);
        reset = 1'b1;
        repeat (2) tick();
        chk("in_rst_press", press, 3'b000);
        chk("in_rst_level", level, 3'b000);
        reset = 1'b0;
        // fresh press at +7 edges, then hold 25 cycles past it for repeats
        for (int t = 1; t <= 32; t++) begin
            int off;
            logic [N-1:0] ep, el;
            tick();
            off = t - 7;
            el  = (t >= 7) ? 3'b001 : 3'b000;
            ep  = 3'b000;
            if (t == 7) ep = 3'b001;
            if (AR && off >= RD && ((off - RD) % RP) == 0) ep = 3'b001;
            chk($sformatf("hold_t%0d_press", t), press, ep);
            chk($sformatf("hold_t%0d_level", t), level, el);
            chk($sformatf("hold_t%0d_release", t), release_pulse, 3'b000);
        end

        btn_raw = 3'b000;
        for (int t = 1; t <= 8; t++) begin
            tick();
            chk($sformatf("rel_t%0d_release", t), release_pulse, (t == 7) ? 3'b001 : 3'b000);
            chk($sformatf("rel_t%0d_level", t), level, (t >= 7) ? 3'b000 : 3'b001);
            chk($sformatf("rel_t%0d_press", t), press, 3'b000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
